// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: ALU memory opcodes, FSM states
// and small opcode classification helpers.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  localparam logic [5:0] ALU_ADD = 6'd0;
  localparam logic [5:0] ALU_LB  = 6'd20;
  localparam logic [5:0] ALU_LH  = 6'd21;
  localparam logic [5:0] ALU_LW  = 6'd22;
  localparam logic [5:0] ALU_LBU = 6'd23;
  localparam logic [5:0] ALU_LHU = 6'd24;
  localparam logic [5:0] ALU_SB  = 6'd25;
  localparam logic [5:0] ALU_SH  = 6'd26;
  localparam logic [5:0] ALU_SW  = 6'd27;

  function automatic logic is_load(input logic [5:0] op);
    return (op == ALU_LB) || (op == ALU_LH) || (op == ALU_LW) ||
           (op == ALU_LBU) || (op == ALU_LHU);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == ALU_SB) || (op == ALU_SH) || (op == ALU_SW);
  endfunction

  function automatic logic is_mem_op(input logic [5:0] op);
    return is_load(op) || is_store(op);
  endfunction

  // Halfwords need an even offset, words need offset zero; bytes are always fine.
  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] off);
    if ((op == ALU_LH) || (op == ALU_LHU) || (op == ALU_SH)) return off[0];
    if ((op == ALU_LW) || (op == ALU_SW)) return off != 2'b00;
    return 1'b0;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store strobe/data replication and
// load data extraction with sign or zero extension.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] sdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_ext_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rdata_i[{off_i, 3'b000} +: 8];
  assign rhalf = rdata_i[{off_i[1], 4'b0000} +: 16];

  always_comb begin
    wstrb_o = 4'b0000;
    wdata_o = '0;
    case (op_i)
      ALU_SB: begin
        wdata_o = {4{sdata_i[7:0]}};
        wstrb_o = 4'b0001 << off_i;
      end
      ALU_SH: begin
        wdata_o = {2{sdata_i[15:0]}};
        wstrb_o = 4'b0011 << off_i;
      end
      ALU_SW: begin
        wdata_o = sdata_i;
        wstrb_o = 4'b1111;
      end
      default: ;
    endcase
  end

  always_comb begin
    rdata_ext_o = '0;
    case (op_i)
      ALU_LB:  rdata_ext_o = {{24{rbyte[7]}}, rbyte};
      ALU_LBU: rdata_ext_o = {24'h000000, rbyte};
      ALU_LH:  rdata_ext_o = {{16{rhalf[15]}}, rhalf};
      ALU_LHU: rdata_ext_o = {16'h0000, rhalf};
      ALU_LW:  rdata_ext_o = rdata_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one req/gnt/rvalid transaction per accepted
// op, stalling the pipeline through busy until the access completes.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [5:0]        alucode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] load_result,
  output logic              misaligned,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic [5:0]        op_q;
  logic [1:0]        off_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        wstrb_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] load_result_q;
  logic              misaligned_q;

  logic              is_idle;
  logic              accept;
  logic              reject;
  logic [5:0]        align_op;
  logic [1:0]        align_off;
  logic [3:0]        wstrb_d;
  logic [DATA_W-1:0] wdata_d;
  logic [DATA_W-1:0] rdata_ext;

  assign is_idle = (state_q == LSU_IDLE);
  assign accept  = is_idle && start && is_mem_op(alucode) && !is_misaligned(alucode, addr[1:0]);
  assign reject  = is_idle && start && is_mem_op(alucode) &&  is_misaligned(alucode, addr[1:0]);

  // In IDLE the aligner looks at the incoming op so store lanes can be latched;
  // afterwards it works on the latched op to extract the returning load data.
  assign align_op  = is_idle ? alucode   : op_q;
  assign align_off = is_idle ? addr[1:0] : off_q;

  lsu_align u_align (
    .op_i        (align_op),
    .off_i       (align_off),
    .sdata_i     (store_data),
    .rdata_i     (mem_rdata),
    .wstrb_o     (wstrb_d),
    .wdata_o     (wdata_d),
    .rdata_ext_o (rdata_ext)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: if (accept)     state_d = LSU_REQ;
      LSU_REQ:  if (mem_gnt)    state_d = LSU_WAIT;
      LSU_WAIT: if (mem_rvalid) state_d = LSU_DONE;
      LSU_DONE:                 state_d = LSU_IDLE;
      default:                  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= LSU_IDLE;
      op_q          <= ALU_ADD;
      off_q         <= 2'b00;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wstrb_q       <= 4'b0000;
      wdata_q       <= '0;
      load_result_q <= '0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      misaligned_q <= reject;
      if (accept) begin
        op_q    <= alucode;
        off_q   <= addr[1:0];
        we_q    <= is_store(alucode);
        addr_q  <= {addr[ADDR_W-1:2], 2'b00};
        wstrb_q <= wstrb_d;
        wdata_q <= wdata_d;
      end
      // Stores leave the previous load result untouched.
      if ((state_q == LSU_WAIT) && mem_rvalid && is_load(op_q)) begin
        load_result_q <= rdata_ext;
      end
    end
  end

  assign busy        = !is_idle;
  assign done        = (state_q == LSU_DONE);
  assign misaligned  = misaligned_q;
  assign load_result = load_result_q;
  assign mem_req     = (state_q == LSU_REQ);
  assign mem_we      = mem_req && we_q;
  assign mem_addr    = addr_q;
  assign mem_wstrb   = wstrb_q;
  assign mem_wdata   = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed ops push expected bus and
// response records; a negedge monitor pops and compares them.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  alucode = ALU_ADD;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic        busy, done, misaligned, mem_req, mem_we;
  logic [31:0] load_result, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  typedef struct {
    bit          isMis;
    bit          isLoad;
    logic [31:0] result;
  } resp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } bus_t;

  resp_t respQ[$];
  bus_t  busQ[$];
  int    compared = 0;
  int    mismatched = 0;

  load_store_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .alucode     (alucode),
    .addr        (addr),
    .store_data  (store_data),
    .busy        (busy),
    .done        (done),
    .load_result (load_result),
    .misaligned  (misaligned),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wstrb   (mem_wstrb),
    .mem_wdata   (mem_wdata),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Responses and bus grants are compared against the queued expectations.
  always @(negedge clk) begin : monitor
    resp_t e;
    bus_t  b;
    if (!rst) begin
      if (done || misaligned) begin
        if (respQ.size() == 0) begin
          checkOutput("unexpected_response", {30'b0, done, misaligned}, 32'h0);
        end else begin
          e = respQ.pop_front();
          checkOutput("resp_misaligned", {31'b0, misaligned}, {31'b0, e.isMis});
          checkOutput("resp_done", {31'b0, done}, {31'b0, !e.isMis});
          if (e.isLoad) checkOutput("load_result", load_result, e.result);
        end
      end
      if (mem_req && mem_gnt) begin
        if (busQ.size() == 0) begin
          checkOutput("unexpected_bus_grant", {31'b0, mem_req}, 32'h0);
        end else begin
          b = busQ.pop_front();
          checkOutput("bus_we", {31'b0, mem_we}, {31'b0, b.we});
          checkOutput("bus_addr", mem_addr, b.addr);
          checkOutput("bus_wstrb", {28'b0, mem_wstrb}, {28'b0, b.wstrb});
          if (b.we) checkOutput("bus_wdata", mem_wdata, b.wdata);
        end
      end
    end
  end

  // Drives start for exactly one cycle; returns one cycle after it was sampled.
  task automatic applyStimulus(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    start = 1'b1; alucode = op; addr = a; store_data = d;
    @(posedge clk); #1;
    start = 1'b0; alucode = ALU_ADD;
  endtask

  task automatic issueOp(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                         input bit expMis, input bit expLoad, input logic [31:0] expResult,
                         input logic [3:0] expStrb, input logic [31:0] expWdata);
    resp_t r;
    bus_t  b;
    r.isMis = expMis; r.isLoad = expLoad; r.result = expResult;
    respQ.push_back(r);
    if (!expMis) begin
      b.we = !expLoad; b.addr = {a[31:2], 2'b00}; b.wstrb = expStrb; b.wdata = expWdata;
      busQ.push_back(b);
    end
    applyStimulus(op, a, d);
  endtask

  // Withholds gnt for gntDelay cycles (checking the request stays stable), then
  // grants; optionally pulses a bogus rvalid alongside gnt before the real one.
  task automatic busCycle(input int gntDelay, input logic [31:0] rd, input bit rvWithGnt,
                          input logic [31:0] expAddr);
    for (int i = 0; i < gntDelay; i++) begin
      @(negedge clk);
      checkOutput("req_held", {31'b0, mem_req}, 32'h1);
      checkOutput("req_addr_stable", mem_addr, expAddr);
      @(posedge clk); #1;
    end
    mem_gnt = 1'b1; mem_rvalid = rvWithGnt; mem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rd;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  initial begin
    #2;
    checkOutput("rst_busy", {31'b0, busy}, 32'h0);
    checkOutput("rst_done", {31'b0, done}, 32'h0);
    checkOutput("rst_misaligned", {31'b0, misaligned}, 32'h0);
    checkOutput("rst_mem_req", {31'b0, mem_req}, 32'h0);
    checkOutput("rst_mem_we", {31'b0, mem_we}, 32'h0);
    checkOutput("rst_load_result", load_result, 32'h0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // LB from byte 3: 0x80 sign-extends; busy spans T+1..T+3.
    issueOp(ALU_LB, 32'h1003, 32'h0, 1'b0, 1'b1, 32'hFFFFFF80, 4'b0000, 32'h0);
    @(negedge clk);
    checkOutput("t1_busy_req", {31'b0, busy}, 32'h1);
    checkOutput("t1_mem_req", {31'b0, mem_req}, 32'h1);
    busCycle(0, 32'h80AABBCC, 1'b0, 32'h1000);
    @(negedge clk);
    checkOutput("t1_busy_done", {31'b0, busy}, 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("t1_busy_after", {31'b0, busy}, 32'h0);

    // SH to upper halfword: replicated data, upper strobes.
    issueOp(ALU_SH, 32'h2002, 32'h1234ABCD, 1'b0, 1'b0, 32'h0, 4'b1100, 32'hABCDABCD);
    busCycle(0, 32'h0, 1'b0, 32'h2000);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("t2_load_hold", load_result, 32'hFFFFFF80);

    // Misaligned LW: single pulse, no bus traffic.
    issueOp(ALU_LW, 32'h3001, 32'h0, 1'b1, 1'b0, 32'h0, 4'b0000, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("t3_no_req", {31'b0, mem_req}, 32'h0);
      checkOutput("t3_not_busy", {31'b0, busy}, 32'h0);
    end

    // LHU upper half with a 5-cycle grant stall and an rvalid alongside gnt.
    issueOp(ALU_LHU, 32'h4002, 32'h0, 1'b0, 1'b1, 32'h0000F00D, 4'b0000, 32'h0);
    busCycle(5, 32'hF00D0000, 1'b1, 32'h4000);
    @(posedge clk); #1;

    // Reset while waiting for rvalid, then a stray rvalid.
    issueOp(ALU_LW, 32'h5000, 32'h0, 1'b0, 1'b1, 32'h0, 4'b0000, 32'h0);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    @(negedge clk);
    checkOutput("t5_busy_wait", {31'b0, busy}, 32'h1);
    #2 rst = 1'b1;
    #1;
    checkOutput("t5_rst_busy", {31'b0, busy}, 32'h0);
    checkOutput("t5_rst_req", {31'b0, mem_req}, 32'h0);
    checkOutput("t5_rst_load_result", load_result, 32'h0);
    checkOutput("t5_rst_mem_addr", mem_addr, 32'h0);
    checkOutput("t5_rst_done", {31'b0, done}, 32'h0);
    respQ.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    checkOutput("t5_stray_busy", {31'b0, busy}, 32'h0);
    checkOutput("t5_stray_load_result", load_result, 32'h0);
    issueOp(ALU_SW, 32'h6000, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 4'b1111, 32'hDEADBEEF);
    busCycle(1, 32'h0, 1'b0, 32'h6000);
    @(posedge clk); #1;

    // Non-memory op is ignored, as is a start while busy.
    applyStimulus(ALU_ADD, 32'h9000, 32'h0);
    @(negedge clk);
    checkOutput("t6_add_busy", {31'b0, busy}, 32'h0);
    checkOutput("t6_add_req", {31'b0, mem_req}, 32'h0);
    issueOp(ALU_LB, 32'h7001, 32'h0, 1'b0, 1'b1, 32'hFFFFFF83, 4'b0000, 32'h0);
    start = 1'b1; alucode = ALU_SW; addr = 32'h8000; store_data = 32'hCAFEF00D;
    @(posedge clk); #1;
    start = 1'b0; alucode = ALU_ADD;
    busCycle(0, 32'h11228344, 1'b0, 32'h7000);
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("t6_idle_after", {31'b0, busy}, 32'h0);
    end

    checkOutput("resp_queue_empty", respQ.size(), 32'h0);
    checkOutput("bus_queue_empty", busQ.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
